// File: rtl/alarm_sequencer_pkg.sv
// Shared anti-theft definitions: state encodings, default delays, clock rate.
package anti_theft_pkg;

    typedef enum logic [2:0] {
        S_ARMED      = 3'd0,
        S_TRIGGERED  = 3'd1,
        S_ALARM      = 3'd2,
        S_ALARM_HOLD = 3'd3,
        S_DISARMED   = 3'd4,
        S_EXIT_OPEN  = 3'd5,
        S_ARM_DELAY  = 3'd6
    } state_t;

    localparam int unsigned CLK_HZ              = 25_000_000;
    localparam int unsigned DUR_W               = 4;
    localparam int unsigned DEF_ARM_DELAY       = 6;
    localparam int unsigned DEF_DRIVER_DELAY    = 8;
    localparam int unsigned DEF_PASSENGER_DELAY = 15;
    localparam int unsigned DEF_ALARM_ON        = 10;

    // Siren sounds while the alarm is active or being held after doors close.
    function automatic logic siren_on(state_t s);
        return (s == S_ALARM) || (s == S_ALARM_HOLD);
    endfunction

    // States in which the LED is lit continuously.
    function automatic logic led_steady(state_t s);
        return (s == S_TRIGGERED) || (s == S_ALARM) ||
               (s == S_ALARM_HOLD) || (s == S_ARM_DELAY);
    endfunction

endpackage

// File: rtl/alarm_sequencer.sv
// Anti-theft sequencer: walks the shared countdown timer through arming,
// entry-delay and alarm-hold intervals and drives the siren and status LED.
module alarm_sequencer
    import anti_theft_pkg::*;
#(
    parameter int unsigned T_ARM_DELAY       = DEF_ARM_DELAY,
    parameter int unsigned T_DRIVER_DELAY    = DEF_DRIVER_DELAY,
    parameter int unsigned T_PASSENGER_DELAY = DEF_PASSENGER_DELAY,
    parameter int unsigned T_ALARM_ON        = DEF_ALARM_ON
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ignition,
    input  logic             driver_door,
    input  logic             passenger_door,
    input  logic             timer_expired,
    input  logic             one_hz_enable,
    output logic             timer_start,
    output logic [DUR_W-1:0] timer_duration,
    output logic             siren,
    output logic             status_led,
    output logic [2:0]       state_code
);

    // A zero duration would never expire, and >15 does not fit the timer.
    generate
        if (T_ARM_DELAY < 1 || T_ARM_DELAY > 15 ||
            T_DRIVER_DELAY < 1 || T_DRIVER_DELAY > 15 ||
            T_PASSENGER_DELAY < 1 || T_PASSENGER_DELAY > 15 ||
            T_ALARM_ON < 1 || T_ALARM_ON > 15) begin : g_bad_delay
            $error("alarm_sequencer: every delay parameter must be in 1..15");
        end
    endgenerate

    state_t             r_state;
    logic               r_timer_start;
    logic [DUR_W-1:0]   r_timer_duration;
    logic               r_siren;
    logic               r_status_led;

    state_t             w_next;
    logic               w_start;
    logic [DUR_W-1:0]   w_dur;
    logic               w_led;
    logic               w_any_door;
    logic               w_qexp;

    assign w_any_door = driver_door | passenger_door;
    // The expired flag may still be high from the previous interval during
    // the start cycle, so it only counts once the start pulse has gone.
    assign w_qexp     = timer_expired & ~r_timer_start;

    // Next-state and timer-start selection; ignition > doors > expiry.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_dur   = r_timer_duration;
        case (r_state)
            S_ARMED: begin
                if (driver_door) begin
                    w_next  = S_TRIGGERED;
                    w_start = 1'b1;
                    w_dur   = DUR_W'(T_DRIVER_DELAY);
                end else if (passenger_door) begin
                    w_next  = S_TRIGGERED;
                    w_start = 1'b1;
                    w_dur   = DUR_W'(T_PASSENGER_DELAY);
                end
            end
            S_TRIGGERED: begin
                if (ignition)    w_next = S_DISARMED;
                else if (w_qexp) w_next = S_ALARM;
            end
            S_ALARM: begin
                if (ignition) begin
                    w_next = S_DISARMED;
                end else if (!w_any_door) begin
                    w_next  = S_ALARM_HOLD;
                    w_start = 1'b1;
                    w_dur   = DUR_W'(T_ALARM_ON);
                end
            end
            S_ALARM_HOLD: begin
                if (ignition)        w_next = S_DISARMED;
                else if (w_any_door) w_next = S_ALARM;
                else if (w_qexp)     w_next = S_ARMED;
            end
            S_DISARMED: begin
                if (!ignition && driver_door) w_next = S_EXIT_OPEN;
            end
            S_EXIT_OPEN: begin
                if (ignition) begin
                    w_next = S_DISARMED;
                end else if (!w_any_door) begin
                    w_next  = S_ARM_DELAY;
                    w_start = 1'b1;
                    w_dur   = DUR_W'(T_ARM_DELAY);
                end
            end
            S_ARM_DELAY: begin
                if (ignition)        w_next = S_DISARMED;
                else if (w_any_door) w_next = S_EXIT_OPEN;
                else if (w_qexp)     w_next = S_ARMED;
            end
            default: w_next = S_ARMED;
        endcase
    end

    // LED value for the next state: blink only while staying in ARMED.
    always_comb begin
        w_led = 1'b0;
        if (w_next == S_ARMED) begin
            w_led = (r_state == S_ARMED) ? (r_status_led ^ one_hz_enable) : 1'b0;
        end else begin
            w_led = led_steady(w_next);
        end
    end

    // State and all outputs register together from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_ARMED;
            r_timer_start    <= 1'b0;
            r_timer_duration <= '0;
            r_siren          <= 1'b0;
            r_status_led     <= 1'b0;
        end else begin
            r_state          <= w_next;
            r_timer_start    <= w_start;
            r_timer_duration <= w_dur;
            r_siren          <= siren_on(w_next);
            r_status_led     <= w_led;
        end
    end

    assign timer_start    = r_timer_start;
    assign timer_duration = r_timer_duration;
    assign siren          = r_siren;
    assign status_led     = r_status_led;
    assign state_code     = r_state;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: behavioural timer, reference model, scoreboard.
module tb_alarm_sequencer;

    localparam int M_ARMED = 0, M_TRIG = 1, M_ALARM = 2, M_HOLD = 3;
    localparam int M_DIS = 4, M_EXIT = 5, M_ARMDLY = 6;
    localparam int D_ARM = 6, D_DRV = 8, D_PAS = 15, D_ON = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ignition = 1'b0;
    logic       driver_door = 1'b0;
    logic       passenger_door = 1'b0;
    logic       force_exp = 1'b0;
    logic       timer_expired, one_hz_enable, timer_start, siren, status_led;
    logic [3:0] timer_duration;
    logic [2:0] state_code;

    alarm_sequencer #(
        .T_ARM_DELAY(D_ARM), .T_DRIVER_DELAY(D_DRV),
        .T_PASSENGER_DELAY(D_PAS), .T_ALARM_ON(D_ON)
    ) dut (
        .clk(clk), .rst(rst), .ignition(ignition),
        .driver_door(driver_door), .passenger_door(passenger_door),
        .timer_expired(timer_expired), .one_hz_enable(one_hz_enable),
        .timer_start(timer_start), .timer_duration(timer_duration),
        .siren(siren), .status_led(status_led), .state_code(state_code)
    );

    always #5 clk = ~clk;

    // Behavioural sibling timer: tick every 10 cycles, real countdown.
    int   tm_cnt = 0;
    int   tm_remain = 0;
    logic tm_tick = 1'b0;
    logic tm_expired = 1'b0;
    always @(posedge clk) begin
        tm_cnt  <= (tm_cnt == 9) ? 0 : tm_cnt + 1;
        tm_tick <= (tm_cnt == 9);
        if (timer_start === 1'b1) begin
            tm_remain  <= int'(timer_duration);
            tm_expired <= 1'b0;
        end else if (tm_tick && tm_remain > 0) begin
            tm_remain <= tm_remain - 1;
            if (tm_remain == 1) tm_expired <= 1'b1;
        end
    end
    assign timer_expired = tm_expired | force_exp;
    assign one_hz_enable = tm_tick;

    typedef struct {
        int st;
        bit start;
        int dur;
        bit sir;
        bit led;
    } exp_t;
    exp_t sb[$];

    int m_state = M_ARMED;
    bit m_start = 1'b0;
    int m_dur   = 0;
    bit m_led   = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;
    int ticks_seen = 0;

    function automatic void chk(string nm, logic [7:0] got, logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, got, want, $time);
        end
    endfunction

    // Reference rules: untimed/armed states first, then ignition for all
    // others, then door-driven moves, then qualified expiry.
    function automatic void model_step(bit r, bit ign, bit dd, bit pd, bit ex, bit tk);
        int s   = m_state;
        int nxt = m_state;
        bit ns  = 1'b0;
        bit any = dd | pd;
        bit qexp = ex & ~m_start;
        if (r) begin
            m_state = M_ARMED; m_start = 1'b0; m_dur = 0; m_led = 1'b0;
        end else begin
            if (s == M_ARMED) begin
                if (any) begin nxt = M_TRIG; ns = 1'b1; m_dur = dd ? D_DRV : D_PAS; end
            end else if (s == M_DIS) begin
                if (!ign && dd) nxt = M_EXIT;
            end else if (ign) begin
                nxt = M_DIS;
            end else if (s == M_TRIG) begin
                if (qexp) nxt = M_ALARM;
            end else if (s == M_ALARM || s == M_EXIT) begin
                if (!any) begin
                    nxt = (s == M_ALARM) ? M_HOLD : M_ARMDLY;
                    ns = 1'b1;
                    m_dur = (s == M_ALARM) ? D_ON : D_ARM;
                end
            end else begin
                if (any)       nxt = (s == M_HOLD) ? M_ALARM : M_EXIT;
                else if (qexp) nxt = M_ARMED;
            end
            if (nxt == M_ARMED) m_led = (s == M_ARMED) ? (m_led ^ tk) : 1'b0;
            else m_led = (nxt == M_TRIG || nxt == M_ALARM || nxt == M_HOLD || nxt == M_ARMDLY);
            m_state = nxt;
            m_start = ns;
        end
        sb.push_back('{m_state, m_start, m_dur, (m_state == M_ALARM || m_state == M_HOLD), m_led});
    endfunction

    // One stimulus cycle: drive at negedge, push the post-edge expectation.
    task automatic cycle(input bit ign, input bit dd, input bit pd,
                         input bit r = 1'b0, input bit fx = 1'b0);
        @(negedge clk);
        rst = r; ignition = ign; driver_door = dd; passenger_door = pd; force_exp = fx;
        if (tm_tick) ticks_seen++;
        model_step(r, ign, dd, pd, tm_expired | fx, tm_tick);
    endtask

    task automatic run_until(input bit ign, input bit dd, input bit pd,
                             input int target, input int max_cyc, input string nm);
        for (int i = 0; i < max_cyc; i++) begin
            cycle(ign, dd, pd);
            if (m_state == target) return;
        end
        n_tests++; n_fail++;
        $display("FAIL %s: state %0d not reached within %0d cycles", nm, target, max_cyc);
    endtask

    task automatic wait_ticks(input int n, input bit ign, input bit dd, input bit pd);
        ticks_seen = 0;
        for (int i = 0; i < 200 && ticks_seen < n; i++) cycle(ign, dd, pd);
    endtask

    // Monitor: every pushed expectation is compared just after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_state", state_code, e.st);
                chk("sb_start", timer_start, e.start);
                chk("sb_dur", timer_duration, e.dur);
                chk("sb_siren", siren, e.sir);
                chk("sb_led", status_led, e.led);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ri = 1'b0, rd = 1'b0, rp = 1'b0;
        cycle(0, 0, 0, 1); cycle(0, 0, 0, 1); cycle(0, 0, 0);
        chk("rst_state", state_code, 0); chk("rst_siren", siren, 0);
        chk("rst_led", status_led, 0); chk("rst_start", timer_start, 0);
        chk("rst_dur", timer_duration, 0);

        // Driver door entry, expiry into ALARM (door held open, ignored).
        cycle(0, 1, 0); cycle(0, 0, 0);
        chk("t1_start", timer_start, 1); chk("t1_dur", timer_duration, D_DRV);
        chk("t1_state", state_code, M_TRIG);
        run_until(0, 1, 0, M_ALARM, 200, "t1_to_alarm");
        cycle(0, 1, 0);
        chk("t1_alarm", state_code, M_ALARM); chk("t1_siren", siren, 1);

        // Alarm hold, reopen, restart, expiry to ARMED.
        cycle(0, 0, 0); cycle(0, 0, 0);
        chk("t3_hold", state_code, M_HOLD); chk("t3_start", timer_start, 1);
        chk("t3_dur", timer_duration, D_ON);
        wait_ticks(4, 0, 0, 0);
        cycle(0, 1, 0); cycle(0, 0, 0);
        chk("t3_realarm", state_code, M_ALARM);
        cycle(0, 0, 0);
        chk("t3_restart", timer_start, 1); chk("t3_redur", timer_duration, D_ON);
        run_until(0, 0, 0, M_ARMED, 300, "t3_to_armed");
        cycle(0, 0, 0);
        chk("t3_armed", state_code, M_ARMED); chk("t3_siren", siren, 0);

        // Passenger entry, ignition disarms.
        cycle(0, 0, 1); cycle(0, 0, 0);
        chk("t2_dur", timer_duration, D_PAS); chk("t2_state", state_code, M_TRIG);
        wait_ticks(5, 0, 0, 0);
        cycle(1, 0, 0); cycle(1, 0, 0);
        chk("t2_dis", state_code, M_DIS); chk("t2_siren", siren, 0);
        chk("t2_led", status_led, 0);

        // Arming sequence with a reopen during the delay.
        cycle(0, 1, 0); cycle(0, 1, 0);
        chk("t4_exit", state_code, M_EXIT);
        cycle(0, 0, 0); cycle(0, 0, 0);
        chk("t4_armdly", state_code, M_ARMDLY); chk("t4_dur", timer_duration, D_ARM);
        wait_ticks(3, 0, 0, 0);
        cycle(0, 1, 0); cycle(0, 0, 0);
        chk("t4_reopen", state_code, M_EXIT);
        cycle(0, 0, 0);
        chk("t4_restart", timer_start, 1); chk("t4_redur", timer_duration, D_ARM);
        run_until(0, 0, 0, M_ARMED, 200, "t4_to_armed");
        cycle(0, 0, 0);
        chk("t4_armed", state_code, M_ARMED); chk("t4_led", status_led, 0);

        // Stale expiry in the start cycle is ignored; next cycle it counts.
        cycle(0, 1, 0); cycle(0, 0, 0, 0, 1);
        chk("t5_trig", state_code, M_TRIG);
        cycle(0, 0, 0, 0, 1);
        chk("t5_stale", state_code, M_TRIG);
        cycle(0, 1, 0);
        chk("t5_qual", state_code, M_ALARM);

        // Reset while in ALARM_HOLD, then LED blinking in ARMED.
        cycle(0, 0, 0); cycle(0, 0, 0);
        chk("t6_hold", state_code, M_HOLD);
        cycle(0, 0, 0, 1); cycle(0, 0, 0);
        chk("t6_state", state_code, M_ARMED); chk("t6_siren", siren, 0);
        chk("t6_start", timer_start, 0);
        repeat (40) cycle(0, 0, 0);

        // Randomised slow-changing levels with rare resets and forced expiry.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) ri = ~ri;
            if ($urandom_range(24) == 0) rd = ~rd;
            if ($urandom_range(29) == 0) rp = ~rp;
            cycle(ri, rd, rp, ($urandom_range(499) == 0), ($urandom_range(49) == 0));
        end

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
